// File: rtl/mac_frame_tx.sv
// rtl/mac_frame_tx.sv - GMII transmit framer: preamble/SFD, zero pad, CRC-32 FCS, inter-frame gap
module mac_frame_tx #(
    parameter int          DATA_LAT      = 2,
    parameter int          END_OFFSET    = 1,
    parameter int          MIN_FRAME     = 60,
    parameter int          MAX_FRAME     = 1514,
    parameter int          IFG_CYCLES    = 12,
    parameter logic [15:0] READY_TIMEOUT = 16'hffff
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       mac_tx_req,
    output logic       mac_tx_ack,
    input  logic       mac_frame_ready,
    output logic       mac_data_req,
    input  logic [7:0] mac_frame_data,
    input  logic       mac_frame_end,
    output logic       mac_send_end,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       tx_busy,
    output logic       tx_err
);

    localparam logic [8:0] S_IDLE     = 9'b000000001;
    localparam logic [8:0] S_ACK      = 9'b000000010;
    localparam logic [8:0] S_WAIT     = 9'b000000100;
    localparam logic [8:0] S_PREAMBLE = 9'b000001000;
    localparam logic [8:0] S_DATA     = 9'b000010000;
    localparam logic [8:0] S_PAD      = 9'b000100000;
    localparam logic [8:0] S_FCS      = 9'b001000000;
    localparam logic [8:0] S_IFG      = 9'b010000000;
    localparam logic [8:0] S_END      = 9'b100000000;

    localparam logic [15:0] MIN_N    = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_N    = 16'(MAX_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = READY_TIMEOUT - 16'd1;
    // Preamble index on which the data request is registered so that it is
    // visible exactly DATA_LAT cycles before the first DATA cycle.
    localparam logic [15:0] DREQ_P   = 16'(7 - DATA_LAT);
    localparam logic [2:0]  END_N    = 3'(END_OFFSET);

    logic [8:0]  state, state_nx;
    logic [15:0] cnt;        // per-state cycle index, cleared on every state change
    logic [15:0] n;          // frame bytes sent so far (data + pad)
    logic [15:0] n_inc;
    logic        end_armed;
    logic [2:0]  end_cnt;
    logic [31:0] crc, crc_upd, crc_inv;
    logic [7:0]  crc_byte;
    logic        is_last, trunc, timeout_hit;

    // Reflected CRC-32 (poly EDB88320), one byte, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign n_inc       = n + 16'd1;
    assign crc_byte    = (state == S_PAD) ? 8'h00 : mac_frame_data;
    assign crc_upd     = crc_next(crc, crc_byte);
    assign crc_inv     = ~crc;
    assign trunc       = (state == S_DATA) && (n == MAX_N);
    assign is_last     = (state == S_DATA) && !trunc &&
                         ((end_armed && end_cnt == 3'd1) ||
                          (END_N == 3'd0 && mac_frame_end && !end_armed));
    assign timeout_hit = (state == S_WAIT) && !mac_frame_ready && (cnt == TO_LAST);

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (mac_tx_req) state_nx = S_ACK;
            S_ACK:      state_nx = S_WAIT;
            S_WAIT: begin
                if (mac_frame_ready)  state_nx = S_PREAMBLE;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_PREAMBLE: if (cnt == 16'd7) state_nx = S_DATA;
            S_DATA: begin
                if (trunc)        state_nx = S_IFG;
                else if (is_last) state_nx = (n_inc < MIN_N) ? S_PAD : S_FCS;
            end
            S_PAD:      if (n_inc >= MIN_N) state_nx = S_FCS;
            S_FCS:      if (cnt == 16'd3) state_nx = S_IFG;
            S_IFG:      if (cnt >= IFG_LAST) state_nx = S_END;
            S_END:      state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // State, counters, end countdown and CRC accumulator.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            n         <= '0;
            end_armed <= 1'b0;
            end_cnt   <= '0;
            crc       <= 32'hFFFFFFFF;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx == state) ? cnt + 16'd1 : 16'd0;

            if (state == S_DATA || state == S_PAD) n <= n_inc;
            else if (state == S_PREAMBLE)          n <= '0;

            if (state == S_DATA || (state == S_PREAMBLE && cnt == 16'd7)) begin
                if (!end_armed && mac_frame_end && END_N != 3'd0) begin
                    end_armed <= 1'b1;
                    end_cnt   <= END_N;
                end else if (end_armed) begin
                    end_cnt <= end_cnt - 3'd1;
                end
            end else begin
                end_armed <= 1'b0;
                end_cnt   <= '0;
            end

            if ((state == S_DATA && !trunc) || state == S_PAD) crc <= crc_upd;
            else if (state != S_FCS)                            crc <= 32'hFFFFFFFF;
        end
    end

    // Registered outputs derived from the current state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mac_tx_ack   <= 1'b0;
            mac_data_req <= 1'b0;
            mac_send_end <= 1'b0;
            gmii_txd     <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            tx_busy      <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            mac_tx_ack   <= (state == S_ACK);
            mac_data_req <= (state == S_PREAMBLE) && (cnt == DREQ_P);
            mac_send_end <= (state == S_END);
            gmii_tx_en   <= (state == S_PREAMBLE) || (state == S_DATA) ||
                            (state == S_PAD) || (state == S_FCS);
            gmii_tx_er   <= trunc;
            tx_busy      <= (state_nx != S_IDLE);
            tx_err       <= trunc || timeout_hit;
            case (state)
                S_PREAMBLE: gmii_txd <= (cnt == 16'd7) ? 8'hD5 : 8'h55;
                S_DATA:     gmii_txd <= trunc ? 8'h00 : mac_frame_data;
                S_FCS: begin
                    case (cnt[1:0])
                        2'd0:    gmii_txd <= crc_inv[7:0];
                        2'd1:    gmii_txd <= crc_inv[15:8];
                        2'd2:    gmii_txd <= crc_inv[23:16];
                        default: gmii_txd <= crc_inv[31:24];
                    endcase
                end
                default:    gmii_txd <= 8'h00;
            endcase
        end
    end

endmodule
